// File: rtl/io_bridge_n_if.sv
// CPU/device-side signal bundle of io_bridge_n; the bridge takes the slave view,
// the CPU plus device models the master view.
interface io_bridge_n_if #(
    parameter int NDEV     = 4,
    parameter int WIN_BITS = 4
);
    logic                  we;
    logic [31:0]           PrAddr;
    logic [31:0]           PrWD;
    logic [NDEV*32-1:0]    devRD;
    logic [NDEV-1:0]       devIRQ;
    logic [31:0]           PrRD;
    logic [31:0]           devWD;
    logic [WIN_BITS-3:0]   devAddr;
    logic [NDEV-1:0]       devWe;
    logic [5:0]            HWint;

    modport slave (
        input  we, PrAddr, PrWD, devRD, devIRQ,
        output PrRD, devWD, devAddr, devWe, HWint
    );

    modport master (
        output we, PrAddr, PrWD, devRD, devIRQ,
        input  PrRD, devWD, devAddr, devWe, HWint
    );
endinterface

// File: rtl/io_bridge_n.sv
// CPU-to-peripheral bridge: NDEV device windows plus one local register window
// holding a maskable edge/level interrupt controller and a sticky bus-error flag.
module io_bridge_n #(
    parameter int          NDEV     = 4,
    parameter logic [31:0] BASE     = 32'h0000_7F00,
    parameter int          WIN_BITS = 4
) (
    input logic         clk,
    input logic         rst,
    io_bridge_n_if.slave bus
);
    localparam logic [31:0] NDEV_W = 32'(NDEV);

    logic [31:0]     off;
    logic [31:0]     slot;
    logic [31:0]     word_idx;
    logic            dev_hit;
    logic            loc_hit;
    logic            unmapped;
    logic [31:0]     loc_rd;
    logic [31:0]     dev_rd;
    logic [NDEV-1:0] dev_we;

    logic [NDEV-1:0] imask;
    logic [NDEV-1:0] imode;
    logic [NDEV-1:0] pend;
    logic [NDEV-1:0] prev;
    logic            err;

    logic [NDEV-1:0] pend_next;
    logic [NDEV-1:0] clr;
    logic            wr_imask;
    logic            wr_imode;
    logic            wr_ipend;
    logic            wr_status;
    logic [5:0]      hw;

    // Address decode; the window offset is taken from BASE-relative address so
    // any BASE alignment that satisfies the window grid decodes correctly.
    always_comb begin
        off      = bus.PrAddr - BASE;
        slot     = off >> WIN_BITS;
        word_idx = 32'(bus.PrAddr[WIN_BITS-1:2]);
        dev_hit  = (bus.PrAddr >= BASE) && (slot < NDEV_W);
        loc_hit  = (bus.PrAddr >= BASE) && (slot == NDEV_W);
        unmapped = !(dev_hit || loc_hit);
    end

    always_comb begin
        dev_we = '0;
        dev_rd = 32'h0;
        for (int i = 0; i < NDEV; i++) begin
            if (dev_hit && slot == 32'(i)) begin
                dev_we[i] = bus.we;
                dev_rd    = bus.devRD[32*i +: 32];
            end
        end
    end

    always_comb begin
        loc_rd = 32'h0;
        if (word_idx == 32'd0) begin
            loc_rd[NDEV-1:0] = imask;
        end else if (word_idx == 32'd1) begin
            loc_rd[NDEV-1:0] = imode;
        end else if (word_idx == 32'd2) begin
            loc_rd[NDEV-1:0] = pend;
        end else if (word_idx == 32'd3) begin
            loc_rd[0]     = err;
            loc_rd[15:8]  = 8'(NDEV);
            loc_rd[23:16] = 8'(WIN_BITS);
        end
    end

    always_comb begin
        wr_imask  = bus.we && loc_hit && (word_idx == 32'd0);
        wr_imode  = bus.we && loc_hit && (word_idx == 32'd1);
        wr_ipend  = bus.we && loc_hit && (word_idx == 32'd2);
        wr_status = bus.we && loc_hit && (word_idx == 32'd3);
        clr       = wr_ipend ? (bus.PrWD[NDEV-1:0] & imode) : '0;
        // Edge mode: a fresh rising edge beats a same-cycle W1C.
        for (int i = 0; i < NDEV; i++) begin
            if (!imode[i]) begin
                pend_next[i] = bus.devIRQ[i];
            end else if (bus.devIRQ[i] && !prev[i]) begin
                pend_next[i] = 1'b1;
            end else if (clr[i]) begin
                pend_next[i] = 1'b0;
            end else begin
                pend_next[i] = pend[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imask <= '0;
            imode <= '0;
            pend  <= '0;
            prev  <= '0;
            err   <= 1'b0;
        end else begin
            if (wr_imask) imask <= bus.PrWD[NDEV-1:0];
            if (wr_imode) imode <= bus.PrWD[NDEV-1:0];
            pend <= pend_next;
            prev <= bus.devIRQ;
            if (bus.we && unmapped) begin
                err <= 1'b1;
            end else if (wr_status && bus.PrWD[0]) begin
                err <= 1'b0;
            end
        end
    end

    // Only registered state feeds the CPU interrupt lines.
    always_comb begin
        hw = 6'b0;
        for (int i = 0; i < NDEV; i++) begin
            hw[i] = pend[i] & imask[i];
        end
    end

    assign bus.devWe   = dev_we;
    assign bus.devWD   = bus.PrWD;
    assign bus.devAddr = bus.PrAddr[WIN_BITS-1:2];
    assign bus.PrRD    = dev_hit ? dev_rd : (loc_hit ? loc_rd : 32'h0);
    assign bus.HWint   = hw;
endmodule

// File: tb/tb_io_bridge_n.sv
// Directed bench for io_bridge_n with NDEV=4, WIN_BITS=4, BASE=0x7F00.
module tb_io_bridge_n;
    localparam logic [31:0] BASE   = 32'h0000_7F00;
    localparam logic [31:0] IMASK  = 32'h0000_7F40;
    localparam logic [31:0] IMODE  = 32'h0000_7F44;
    localparam logic [31:0] IPEND  = 32'h0000_7F48;
    localparam logic [31:0] STATUS = 32'h0000_7F4C;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] rd;

    io_bridge_n_if #(.NDEV(4), .WIN_BITS(4)) bus ();

    io_bridge_n #(.NDEV(4), .BASE(BASE), .WIN_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.we     = 1'b1;
        bus.PrAddr = addr;
        bus.PrWD   = data;
        step();
        bus.we     = 1'b0;
        #1;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus.we     = 1'b0;
        bus.PrAddr = addr;
        #1;
        data = bus.PrRD;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        bus.we       = 1'b0;
        bus.PrAddr   = 32'h0;
        bus.PrWD     = 32'h0;
        bus.devIRQ   = 4'h0;
        bus.devRD    = {32'hAAAA_0003, 32'h0000_1234, 32'hAAAA_0001, 32'hAAAA_0000};
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_hwint", {26'b0, bus.HWint}, 32'h0);
        bus_read(IMASK, rd);  check("rst_imask", rd, 32'h0);
        bus_read(IMODE, rd);  check("rst_imode", rd, 32'h0);
        bus_read(IPEND, rd);  check("rst_ipend", rd, 32'h0);
        bus_read(STATUS, rd); check("rst_status", rd, 32'h0004_0400);

        // Device write / read pass-through
        bus.we     = 1'b1;
        bus.PrAddr = BASE + 32'h24;
        bus.PrWD   = 32'hDEAD_BEEF;
        #1;
        check("dev_we", {28'b0, bus.devWe}, 32'h4);
        check("dev_addr", {30'b0, bus.devAddr}, 32'h1);
        check("dev_wd", bus.devWD, 32'hDEAD_BEEF);
        step();
        bus.we = 1'b0;
        #1;
        check("dev_we_off", {28'b0, bus.devWe}, 32'h0);
        bus_read(BASE + 32'h24, rd); check("dev2_rd", rd, 32'h0000_1234);
        bus_read(BASE + 32'h0C, rd); check("dev0_rd", rd, 32'hAAAA_0000);
        bus_read(BASE + 32'h30, rd); check("dev3_rd", rd, 32'hAAAA_0003);

        // Local write visible next cycle; level-mode interrupt timing
        bus_write(IMASK, 32'hFFFF_FFFF);
        bus_read(IMASK, rd); check("imask_rd", rd, 32'h0000_000F);
        bus_write(IMODE, 32'h0);
        bus.devIRQ = 4'h2;
        #1; check("lvl_c10", {26'b0, bus.HWint}, 32'h0);
        step(); check("lvl_c11", {26'b0, bus.HWint}, 32'h2);
        step(); check("lvl_c12", {26'b0, bus.HWint}, 32'h2);
        step(); bus.devIRQ = 4'h0;
        #1; check("lvl_c13", {26'b0, bus.HWint}, 32'h2);
        step(); check("lvl_c14", {26'b0, bus.HWint}, 32'h0);

        // Edge mode: sticky, W1C, set beats clear, held-high no re-set
        bus_write(IMODE, 32'h1);
        bus_write(IMASK, 32'h1);
        bus.devIRQ = 4'h1;
        step();
        bus.devIRQ = 4'h0;
        #1; check("edge_set", {26'b0, bus.HWint}, 32'h1);
        step(); step();
        check("edge_sticky", {26'b0, bus.HWint}, 32'h1);
        bus_read(IPEND, rd); check("ipend_rd", rd, 32'h1);
        bus_write(IPEND, 32'h1);
        check("edge_clr", {26'b0, bus.HWint}, 32'h0);
        bus.devIRQ = 4'h1;
        bus_write(IPEND, 32'h1);
        check("edge_set_wins", {26'b0, bus.HWint}, 32'h1);
        bus_write(IPEND, 32'h1);
        check("edge_held_clr", {26'b0, bus.HWint}, 32'h0);
        step(); step();
        check("edge_held_no_reset", {26'b0, bus.HWint}, 32'h0);
        bus.devIRQ = 4'h0;
        step();

        // Unmapped access and sticky error
        bus.we     = 1'b1;
        bus.PrAddr = BASE + 32'h60;
        bus.PrWD   = 32'h5555_5555;
        #1; check("unm_we", {28'b0, bus.devWe}, 32'h0);
        step();
        bus.we = 1'b0;
        bus_read(STATUS, rd); check("err_set", rd, 32'h0004_0401);
        bus_read(BASE + 32'h60, rd); check("unm_rd", rd, 32'h0);
        bus_read(BASE - 32'h4, rd); check("below_rd", rd, 32'h0);
        bus_write(STATUS, 32'h1);
        bus_read(STATUS, rd); check("err_clr", rd, 32'h0004_0400);

        // Asynchronous reset mid-cycle
        bus_write(IMODE, 32'h0);
        bus_write(IMASK, 32'hF);
        bus.devIRQ = 4'hF;
        step();
        check("pre_rst_hwint", {26'b0, bus.HWint}, 32'hF);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_hwint", {26'b0, bus.HWint}, 32'h0);
        bus_read(IMASK, rd); check("async_rst_imask", rd, 32'h0);
        step();
        rst = 1'b0;
        bus.devIRQ = 4'h0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
